// File: rtl/inst_decoder.sv
// RV32I decode stage: extracts fields and immediates and classifies each instruction into
// register/ALU, memory and branch control bundles. cycleNum=2 puts an input register ahead of decode.
package inst_decoder_pkg;
  localparam int cXLEN = 32;
endpackage

module inst_decoder
  import inst_decoder_pkg::*;
#(
  parameter int cycleNum = 2
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [cXLEN-1:0] iInst,
  input  logic [cXLEN-1:0] iCurPC,
  input  logic             iFlushPipe,
  output logic [106:0]     oDecoded,
  output logic [8:0]       oRegOp,
  output logic [5:0]       oMemOp,
  output logic [6:0]       oBranchOp
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  function automatic logic [3:0] f_alu(input logic [2:0] f3, input logic alt);
    f_alu = ALU_ADD;
    case (f3)
      3'd0:    f_alu = alt ? ALU_SUB : ALU_ADD;
      3'd1:    f_alu = ALU_SLL;
      3'd2:    f_alu = ALU_SLT;
      3'd3:    f_alu = ALU_SLTU;
      3'd4:    f_alu = ALU_XOR;
      3'd5:    f_alu = alt ? ALU_SRA : ALU_SRL;
      3'd6:    f_alu = ALU_OR;
      default: f_alu = ALU_AND;
    endcase
  endfunction

  logic [cXLEN-1:0] w_inst;
  logic [cXLEN-1:0] w_pc;
  logic             w_vld;

  // w_vld marks a stage-1 slot that holds a real instruction rather than reset/flush residue
  generate
    if (cycleNum == 2) begin : g_in_reg
      logic [cXLEN-1:0] r_inst;
      logic [cXLEN-1:0] r_pc;
      logic             r_vld;
      always_ff @(posedge iClk) begin
        if (iRst || iFlushPipe) begin
          r_inst <= '0;
          r_pc   <= '0;
          r_vld  <= 1'b0;
        end else begin
          r_inst <= iInst;
          r_pc   <= iCurPC;
          r_vld  <= 1'b1;
        end
      end
      assign w_inst = r_inst;
      assign w_pc   = r_pc;
      assign w_vld  = r_vld;
    end else begin : g_no_in_reg
      assign w_inst = iInst;
      assign w_pc   = iCurPC;
      assign w_vld  = 1'b1;
    end
  endgenerate

  logic [6:0]       w_opcode;
  logic [2:0]       w_funct3;
  logic [6:0]       w_funct7;
  logic [4:0]       w_rd;
  logic [4:0]       w_rs1;
  logic [4:0]       w_rs2;
  logic [cXLEN-1:0] w_imm_i;
  logic [cXLEN-1:0] w_imm_s;
  logic [cXLEN-1:0] w_imm_b;
  logic [cXLEN-1:0] w_imm_u;
  logic [cXLEN-1:0] w_imm_j;

  assign w_opcode = w_inst[6:0];
  assign w_funct3 = w_inst[14:12];
  assign w_funct7 = w_inst[31:25];
  assign w_rd     = w_inst[11:7];
  assign w_rs1    = w_inst[19:15];
  assign w_rs2    = w_inst[24:20];
  assign w_imm_i  = {{20{w_inst[31]}}, w_inst[31:20]};
  assign w_imm_s  = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
  assign w_imm_b  = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
  assign w_imm_u  = {w_inst[31:12], 12'b0};
  assign w_imm_j  = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

  logic [cXLEN-1:0] w_imm;
  logic             w_legal;
  logic             w_rvalid, w_rdwr, w_useimm, w_islui, w_isauipc;
  logic [3:0]       w_aluop;
  logic             w_mvalid, w_load, w_store, w_uns;
  logic [1:0]       w_size;
  logic             w_bvalid, w_jal, w_jalr, w_br;
  logic [2:0]       w_cond;
  logic [8:0]       w_regop;
  logic [5:0]       w_memop;
  logic [6:0]       w_brop;

  always_comb begin
    w_imm     = '0;
    w_legal   = 1'b0;
    w_rvalid  = 1'b0;
    w_rdwr    = 1'b0;
    w_aluop   = ALU_ADD;
    w_useimm  = 1'b0;
    w_islui   = 1'b0;
    w_isauipc = 1'b0;
    w_mvalid  = 1'b0;
    w_load    = 1'b0;
    w_store   = 1'b0;
    w_size    = 2'd0;
    w_uns     = 1'b0;
    w_bvalid  = 1'b0;
    w_jal     = 1'b0;
    w_jalr    = 1'b0;
    w_br      = 1'b0;
    w_cond    = 3'd0;
    case (w_opcode)
      OPC_LUI, OPC_AUIPC: begin
        w_legal   = 1'b1;
        w_rvalid  = 1'b1;
        w_rdwr    = 1'b1;
        w_useimm  = 1'b1;
        w_islui   = (w_opcode == OPC_LUI);
        w_isauipc = (w_opcode == OPC_AUIPC);
        w_imm     = w_imm_u;
      end
      OPC_JAL: begin
        w_legal  = 1'b1;
        w_rvalid = 1'b1;
        w_rdwr   = 1'b1;
        w_bvalid = 1'b1;
        w_jal    = 1'b1;
        w_imm    = w_imm_j;
      end
      OPC_JALR: begin
        w_legal  = (w_funct3 == 3'd0);
        w_rvalid = 1'b1;
        w_rdwr   = 1'b1;
        w_useimm = 1'b1;
        w_bvalid = 1'b1;
        w_jalr   = 1'b1;
        w_imm    = w_imm_i;
      end
      OPC_BRANCH: begin
        w_legal  = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
        w_bvalid = 1'b1;
        w_br     = 1'b1;
        w_cond   = w_funct3;
        w_imm    = w_imm_b;
      end
      OPC_LOAD: begin
        w_legal  = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) && (w_funct3 != 3'b111);
        w_rvalid = 1'b1;
        w_rdwr   = 1'b1;
        w_useimm = 1'b1;
        w_mvalid = 1'b1;
        w_load   = 1'b1;
        w_size   = w_funct3[1:0];
        w_uns    = w_funct3[2];
        w_imm    = w_imm_i;
      end
      OPC_STORE: begin
        w_legal  = (w_funct3 < 3'd3);
        w_mvalid = 1'b1;
        w_store  = 1'b1;
        w_size   = w_funct3[1:0];
        w_imm    = w_imm_s;
      end
      OPC_OPIMM: begin
        // shift-immediates carry funct7 in imm[11:5]; only SRAI may set bit 5
        w_legal  = (w_funct3 == 3'd1) ? (w_funct7 == 7'd0) :
                   (w_funct3 == 3'd5) ? ((w_funct7 == 7'd0) || (w_funct7 == 7'h20)) : 1'b1;
        w_rvalid = 1'b1;
        w_rdwr   = 1'b1;
        w_useimm = 1'b1;
        w_aluop  = f_alu(w_funct3, (w_funct3 == 3'd5) && w_funct7[5]);
        w_imm    = w_imm_i;
      end
      OPC_OP: begin
        w_legal  = (w_funct7 == 7'd0) ||
                   ((w_funct7 == 7'h20) && ((w_funct3 == 3'd0) || (w_funct3 == 3'd5)));
        w_rvalid = 1'b1;
        w_rdwr   = 1'b1;
        w_aluop  = f_alu(w_funct3, w_funct7[5]);
      end
      default: w_legal = 1'b0;
    endcase
    if (w_rd == 5'd0) w_rdwr = 1'b0;
  end

  assign w_regop = w_legal ? {w_rvalid, w_rdwr, w_aluop, w_useimm, w_islui, w_isauipc} : '0;
  assign w_memop = w_legal ? {w_mvalid, w_load, w_store, w_size, w_uns} : '0;
  assign w_brop  = w_legal ? {w_bvalid, w_jal, w_jalr, w_br, w_cond} : '0;

  logic [106:0] r_decoded;
  logic [8:0]   r_regop;
  logic [5:0]   r_memop;
  logic [6:0]   r_brop;

  always_ff @(posedge iClk) begin
    if (iRst || iFlushPipe || !w_vld) begin
      r_decoded <= '0;
      r_regop   <= '0;
      r_memop   <= '0;
      r_brop    <= '0;
    end else begin
      r_decoded <= {w_pc, w_imm, w_opcode, w_funct3, w_funct7, w_rd, w_rs1, w_rs2, w_legal, 10'd0};
      r_regop   <= w_regop;
      r_memop   <= w_memop;
      r_brop    <= w_brop;
    end
  end

  assign oDecoded  = r_decoded;
  assign oRegOp    = r_regop;
  assign oMemOp    = r_memop;
  assign oBranchOp = r_brop;

endmodule

// File: tb/tb_inst_decoder.sv
// Directed bench for inst_decoder: reset, per-class decode vectors, illegal words, flush and reset+flush.
module tb_inst_decoder;
  localparam int CYC = 2;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] ADDI = 32'h00510093;

  logic         iClk = 1'b0;
  logic         iRst;
  logic [31:0]  iInst;
  logic [31:0]  iCurPC;
  logic         iFlushPipe;
  logic [106:0] oDecoded;
  logic [8:0]   oRegOp;
  logic [5:0]   oMemOp;
  logic [6:0]   oBranchOp;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] inst;
    logic [8:0]  reg_op;
    logic [5:0]  mem_op;
    logic [6:0]  br_op;
    logic [31:0] imm;
    logic        legal;
  } vec_t;

  vec_t vecs [21];

  inst_decoder #(.cycleNum(CYC)) dut (
    .iClk(iClk), .iRst(iRst), .iInst(iInst), .iCurPC(iCurPC), .iFlushPipe(iFlushPipe),
    .oDecoded(oDecoded), .oRegOp(oRegOp), .oMemOp(oMemOp), .oBranchOp(oBranchOp)
  );

  always #5 iClk = ~iClk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    iInst  = inst;
    iCurPC = pc;
    @(posedge iClk);
    #1;
  endtask

  task automatic init_vecs;
    vecs[0]  = '{32'h00510093, 9'h184, 6'b000000, 7'b0000000, 32'h00000005, 1'b1}; // addi x1,x2,5
    vecs[1]  = '{32'h00532423, 9'h000, 6'b101100, 7'b0000000, 32'h00000008, 1'b1}; // sw x5,8(x6)
    vecs[2]  = '{32'hFE208EE3, 9'h000, 6'b000000, 7'b1001000, 32'hFFFFFFFC, 1'b1}; // beq -4
    vecs[3]  = '{32'h123451B7, 9'h186, 6'b000000, 7'b0000000, 32'h12345000, 1'b1}; // lui
    vecs[4]  = '{32'h00001117, 9'h185, 6'b000000, 7'b0000000, 32'h00001000, 1'b1}; // auipc
    vecs[5]  = '{32'h008000EF, 9'h180, 6'b000000, 7'b1100000, 32'h00000008, 1'b1}; // jal x1,+8
    vecs[6]  = '{32'h00008067, 9'h104, 6'b000000, 7'b1010000, 32'h00000000, 1'b1}; // jalr x0
    vecs[7]  = '{32'h0000A003, 9'h104, 6'b110100, 7'b0000000, 32'h00000000, 1'b1}; // lw x0
    vecs[8]  = '{32'hFFF0C283, 9'h184, 6'b110001, 7'b0000000, 32'hFFFFFFFF, 1'b1}; // lbu -1
    vecs[9]  = '{32'h402081B3, 9'h188, 6'b000000, 7'b0000000, 32'h00000000, 1'b1}; // sub
    vecs[10] = '{32'h40325213, 9'h1BC, 6'b000000, 7'b0000000, 32'h00000403, 1'b1}; // srai
    vecs[11] = '{32'h40000093, 9'h184, 6'b000000, 7'b0000000, 32'h00000400, 1'b1}; // addi imm[10]
    vecs[12] = '{32'h0020E863, 9'h000, 6'b000000, 7'b1001110, 32'h00000010, 1'b1}; // bltu +16
    vecs[13] = '{32'h00111123, 9'h000, 6'b101010, 7'b0000000, 32'h00000002, 1'b1}; // sh
    vecs[14] = '{32'h0000B083, 9'h000, 6'b000000, 7'b0000000, 32'h00000000, 1'b0}; // load f3=011
    vecs[15] = '{32'h0020A063, 9'h000, 6'b000000, 7'b0000000, 32'h00000000, 1'b0}; // branch f3=010
    vecs[16] = '{32'h00000000, 9'h000, 6'b000000, 7'b0000000, 32'h00000000, 1'b0};
    vecs[17] = '{32'hFFFFFFFF, 9'h000, 6'b000000, 7'b0000000, 32'h00000000, 1'b0};
    vecs[18] = '{32'h40209133, 9'h000, 6'b000000, 7'b0000000, 32'h00000000, 1'b0}; // sll with f7=0x20
    vecs[19] = '{32'hFFF0C093, 9'h1AC, 6'b000000, 7'b0000000, 32'hFFFFFFFF, 1'b1}; // xori -1
    vecs[20] = '{32'h007332B3, 9'h1A0, 6'b000000, 7'b0000000, 32'h00000000, 1'b1}; // sltu
  endtask

  task automatic test_reset;
    iRst = 1'b1;
    iFlushPipe = 1'b0;
    for (int i = 0; i < 100; i++) begin
      push(ADDI, 32'h0);
      n_cmp++;
      if ({oDecoded, oRegOp, oMemOp, oBranchOp} !== '0) begin
        n_err++;
        $display("FAIL reset_hold cycle %0d: got dec=%h reg=%h mem=%h br=%h want all zero",
                 i, oDecoded, oRegOp, oMemOp, oBranchOp);
      end
    end
    iRst = 1'b0;
    for (int e = 1; e <= CYC; e++) begin
      push(ADDI, 32'h100 + 32'(4 * (e - 1)));
      n_cmp++;
      if (e < CYC) begin
        if ({oDecoded, oRegOp, oMemOp, oBranchOp} !== '0) begin
          n_err++;
          $display("FAIL reset_release edge %0d: got reg=%h dec=%h want zero", e, oRegOp, oDecoded);
        end
      end else if (oDecoded[106:75] !== 32'h100 || oRegOp !== 9'h184) begin
        n_err++;
        $display("FAIL reset_first_word: got pc=%h reg=%h want pc=00000100 reg=184",
                 oDecoded[106:75], oRegOp);
      end
    end
  endtask

  task automatic test_full_words;
    logic [106:0] exp_dec;
    push(ADDI, 32'h00000500);
    for (int k = 0; k < CYC - 1; k++) push(NOP, 32'h0);
    exp_dec = {32'h00000500, 32'd5, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd5, 1'b1, 10'd0};
    n_cmp++;
    if (oDecoded !== exp_dec || oMemOp !== 6'd0 || oBranchOp !== 7'd0) begin
      n_err++;
      $display("FAIL addi_word: got dec=%h mem=%h br=%h want dec=%h mem=0 br=0",
               oDecoded, oMemOp, oBranchOp, exp_dec);
    end
    push(32'hFFFFFFFF, 32'h00000504);
    for (int k = 0; k < CYC - 1; k++) push(NOP, 32'h0);
    exp_dec = {32'h00000504, 32'd0, 7'h7F, 3'h7, 7'h7F, 5'h1F, 5'h1F, 5'h1F, 1'b0, 10'd0};
    n_cmp++;
    if (oDecoded !== exp_dec || oRegOp !== 9'd0 || oMemOp !== 6'd0 || oBranchOp !== 7'd0) begin
      n_err++;
      $display("FAIL ones_word: got dec=%h reg=%h mem=%h br=%h want dec=%h bundles zero",
               oDecoded, oRegOp, oMemOp, oBranchOp, exp_dec);
    end
  endtask

  task automatic test_vectors;
    logic [31:0] pc;
    for (int i = 0; i < 21; i++) begin
      pc = 32'h1000 + 32'(4 * i);
      push(vecs[i].inst, pc);
      for (int k = 0; k < CYC - 1; k++) push(NOP, 32'h0);
      n_cmp++;
      if (oRegOp !== vecs[i].reg_op || oMemOp !== vecs[i].mem_op || oBranchOp !== vecs[i].br_op) begin
        n_err++;
        $display("FAIL vec%0d_bundles inst=%h: got reg=%h mem=%h br=%h want reg=%h mem=%h br=%h",
                 i, vecs[i].inst, oRegOp, oMemOp, oBranchOp,
                 vecs[i].reg_op, vecs[i].mem_op, vecs[i].br_op);
      end
      n_cmp++;
      if (oDecoded[74:43] !== vecs[i].imm || oDecoded[10] !== vecs[i].legal ||
          oDecoded[106:75] !== pc || oDecoded[9:0] !== 10'd0) begin
        n_err++;
        $display("FAIL vec%0d_fields inst=%h: got imm=%h legal=%b pc=%h rsvd=%h want imm=%h legal=%b pc=%h rsvd=0",
                 i, vecs[i].inst, oDecoded[74:43], oDecoded[10], oDecoded[106:75], oDecoded[9:0],
                 vecs[i].imm, vecs[i].legal, pc);
      end
    end
  endtask

  task automatic test_back_to_back_flush;
    int e;
    for (int j = 0; j < 10; j++) begin
      iFlushPipe = (j == 3);
      push(vecs[j].inst, 32'h2000 + 32'(4 * j));
      e = j - (CYC - 1);
      if (j >= 3 && j <= 3 + CYC - 1) begin
        n_cmp++;
        if ({oDecoded, oRegOp, oMemOp, oBranchOp} !== '0) begin
          n_err++;
          $display("FAIL flush_zero edge %0d: got pc=%h reg=%h mem=%h br=%h want all zero",
                   j, oDecoded[106:75], oRegOp, oMemOp, oBranchOp);
        end
      end else if (e >= 0) begin
        n_cmp++;
        if (oDecoded[106:75] !== 32'h2000 + 32'(4 * e) || oRegOp !== vecs[e].reg_op ||
            oMemOp !== vecs[e].mem_op || oBranchOp !== vecs[e].br_op) begin
          n_err++;
          $display("FAIL stream edge %0d: got pc=%h reg=%h mem=%h br=%h want pc=%h reg=%h mem=%h br=%h",
                   j, oDecoded[106:75], oRegOp, oMemOp, oBranchOp,
                   32'h2000 + 32'(4 * e), vecs[e].reg_op, vecs[e].mem_op, vecs[e].br_op);
        end
      end
    end
    iFlushPipe = 1'b0;
  endtask

  task automatic test_flush_hold;
    iFlushPipe = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(ADDI, 32'h3000);
      n_cmp++;
      if ({oDecoded, oRegOp, oMemOp, oBranchOp} !== '0) begin
        n_err++;
        $display("FAIL flush_hold cycle %0d: got reg=%h dec=%h want zero", i, oRegOp, oDecoded);
      end
    end
    iFlushPipe = 1'b0;
    for (int e = 1; e <= CYC; e++) push(ADDI, 32'h3100 + 32'(4 * (e - 1)));
    n_cmp++;
    if (oDecoded[106:75] !== 32'h3100 || oRegOp !== 9'h184) begin
      n_err++;
      $display("FAIL flush_resume: got pc=%h reg=%h want pc=00003100 reg=184", oDecoded[106:75], oRegOp);
    end
  endtask

  task automatic test_reset_and_flush;
    push(vecs[5].inst, 32'h3F00);
    iRst = 1'b1;
    iFlushPipe = 1'b1;
    push(ADDI, 32'h3F04);
    n_cmp++;
    if ({oDecoded, oRegOp, oMemOp, oBranchOp} !== '0) begin
      n_err++;
      $display("FAIL rst_flush_zero: got reg=%h br=%h want zero", oRegOp, oBranchOp);
    end
    iRst = 1'b0;
    iFlushPipe = 1'b0;
    for (int e = 1; e <= CYC; e++) begin
      push(vecs[8].inst, 32'h4000 + 32'(4 * (e - 1)));
      if (e < CYC) begin
        n_cmp++;
        if ({oDecoded, oRegOp, oMemOp, oBranchOp} !== '0) begin
          n_err++;
          $display("FAIL rst_flush_release edge %0d: got reg=%h mem=%h want zero", e, oRegOp, oMemOp);
        end
      end
    end
    n_cmp++;
    if (oDecoded[106:75] !== 32'h4000 || oMemOp !== 6'b110001 || oRegOp !== 9'h184) begin
      n_err++;
      $display("FAIL rst_flush_first: got pc=%h mem=%h reg=%h want pc=00004000 mem=31 reg=184",
               oDecoded[106:75], oMemOp, oRegOp);
    end
  endtask

  initial begin
    iRst = 1'b1;
    iFlushPipe = 1'b0;
    iInst = ADDI;
    iCurPC = 32'h0;
    init_vecs();
    test_reset();
    test_full_words();
    test_vectors();
    test_back_to_back_flush();
    test_flush_hold();
    test_reset_and_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
